// File: rtl/div_ctrl_pkg.sv
// Shared encodings and constants for the radix-2 restoring divider (div_ctrl).
// The stall bus width lives in the shared pipeline defines, not here.
package div_ctrl_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 6;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_t;

  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;
  localparam logic Stop     = 1'b1;
  localparam logic NoStop   = 1'b0;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it is non-negative.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic              next_bit,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic              q_bit
);

  logic [DATA_W:0] partial;
  logic [DATA_W:0] diff;

  // rem < divisor always holds, so the difference fits in DATA_W+1 signed bits.
  assign partial  = {rem, next_bit};
  assign diff     = partial - {1'b0, divisor};
  assign q_bit    = ~diff[DATA_W];
  assign rem_next = q_bit ? diff[DATA_W-1:0] : partial[DATA_W-1:0];

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU unit for the EX stage: magnitudes are divided one bit per
// cycle, then sign-corrected. Define DIV_EARLY_OUT_EN to finish |op1|<|op2| at once.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                signed_i,
  input  logic                annul_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o,
  output logic [1:0]          dbg_state
);

  div_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                neg_q_q, neg_q_d;
  logic                neg_r_q, neg_r_d;
  logic [2*DATA_W-1:0] result_d;

  logic [DATA_W-1:0]   abs1, abs2;
  logic [DATA_W-1:0]   step_rem;
  logic                step_q;
  logic [DATA_W-1:0]   quo_step;
  logic [DATA_W-1:0]   q_fix, r_fix;

  // Signed operands are reduced to magnitudes; -2^(DATA_W-1) stays as the unsigned value.
  assign abs1 = (signed_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign abs2 = (signed_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // quo_q shifts dividend bits out at the top while quotient bits enter at the bottom.
  div_step #(.DATA_W(DATA_W)) u_step (
    .rem      (rem_q),
    .next_bit (quo_q[DATA_W-1]),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  assign quo_step  = {quo_q[DATA_W-2:0], step_q};
  assign q_fix     = neg_q_q ? -quo_step : quo_step;
  assign r_fix     = neg_r_q ? -step_rem : step_rem;
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    result_d   = result_o;
    stallreq_o = NoStop;
    ready_o    = 1'b0;
    case (state_q)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          stallreq_o = Stop;
          if (opdata2_i == '0) begin
            state_d = DivByZero;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (abs1 < abs2) begin
            state_d  = DivEnd;
            result_d = {opdata1_i, {DATA_W{1'b0}}};
          end
`endif
          else begin
            state_d = DivOn;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = abs1;
            dvs_d   = abs2;
            neg_q_d = signed_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_r_d = signed_i && opdata1_i[DATA_W-1];
          end
        end
      end
      DivByZero: begin
        if (annul_i) begin
          state_d = DivFree;
        end else begin
          stallreq_o = Stop;
          state_d    = DivEnd;
          result_d   = '0;
        end
      end
      DivOn: begin
        if (annul_i) begin
          state_d = DivFree;
        end else begin
          stallreq_o = Stop;
          cnt_d      = cnt_q + 1'b1;
          rem_d      = step_rem;
          quo_d      = quo_step;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d  = DivEnd;
            result_d = {r_fix, q_fix};
          end
        end
      end
      DivEnd: begin
        ready_o = 1'b1;
        state_d = DivFree;
      end
      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_o <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      result_o <= result_d;
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: directed cases plus random divides, scored against a
// plain-arithmetic reference (64-bit integer division) through an expected queue.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i;
  logic           signed_i;
  logic           annul_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           stallreq_o;
  logic [1:0]     dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [2*W-1:0] exp_q[$];
  int             exp_cyc_q[$];
  logic [2*W-1:0] last_res;
  logic [2*W-1:0] mon_e;
  int             mon_ec;

  div_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .annul_i    (annul_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o),
    .dbg_state  (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: truncating integer division on 64-bit values.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    longint q, r, sa, sb;
    if (b == 0) return '0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int latency(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint ma, mb;
    if (b == 0) return 2;
    ma = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    mb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`endif
    return 33;
  endfunction

  // monitor: every ready_o pops one expectation; a late or missing ready is flagged.
  always @(negedge clk) begin
    if (ready_o) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got ready with result %h, want no ready (cycle %0d)",
                 result_o, cyc);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_ec = exp_cyc_q.pop_front();
        check("result", result_o, mon_e);
        check("ready_cycle", 64'(cyc), 64'(mon_ec));
      end
    end else if (exp_cyc_q.size() > 0 && cyc > exp_cyc_q[0]) begin
      total++;
      bad++;
      $display("FAIL missing_ready: got no ready by cycle %0d, want ready at %0d",
               cyc, exp_cyc_q[0]);
      mon_e  = exp_q.pop_front();
      mon_ec = exp_cyc_q.pop_front();
    end
  end

  // driver: present one op like a stalled EX stage; optionally annul/reset at offset k.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input int annul_at, input int rst_at);
    int lat;
    int t0;
    logic killed;
    logic [63:0] exp_r;
    @(negedge clk);
    #1;
    check("result_held", result_o, last_res);
    lat    = latency(a, b, sgn);
    exp_r  = ref_div(a, b, sgn);
    killed = (annul_at >= 1 && annul_at < lat) || (rst_at >= 1 && rst_at < lat);
    t0     = cyc;
    if (!killed) begin
      exp_q.push_back(exp_r);
      exp_cyc_q.push_back(t0 + lat);
    end
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) @(negedge clk);
      start_i = (k < lat);
      annul_i = (k == annul_at);
      rst     = (k == rst_at);
      if (k == 0) begin
        opdata1_i = a;
        opdata2_i = b;
        signed_i  = sgn;
      end else begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_i  = 1'($urandom_range(0, 1));
      end
      #1;
      check("stallreq", stallreq_o, (k < lat && k != annul_at));
      if (k < lat && (k == annul_at || k == rst_at)) begin
        @(negedge clk);
        annul_i = 1'b0;
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        check("stall_after_kill", stallreq_o, 0);
        check("state_after_kill", dbg_state, DivFree);
        check("ready_after_kill", ready_o, 0);
        if (k == rst_at) begin
          last_res = '0;
          check("result_after_rst", result_o, 0);
        end
        return;
      end
    end
    annul_i  = 1'b0;
    start_i  = 1'b0;
    last_res = exp_r;
  endtask

  initial begin
    logic [31:0] a, b;
    int annul_at;
    rst       = 1'b1;
    start_i   = 1'b0;
    signed_i  = 1'b0;
    annul_i   = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    last_res  = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_result", result_o, 0);
    check("reset_ready", ready_o, 0);
    check("reset_stall", stallreq_o, 0);
    check("reset_state", dbg_state, DivFree);
    rst = 1'b0;

    run_op(32'd100, 32'd7, 1'b0, -1, -1);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, -1, -1);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, -1, -1);
    run_op(32'd5, 32'd0, 1'b1, -1, -1);
    run_op(32'hFFFF_FFFF, 32'd3, 1'b0, 10, -1);
    run_op(32'h1234_5678, 32'h11, 1'b0, -1, 20);
    run_op(32'd9, 32'd3, 1'b0, -1, -1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, -1);
    run_op(32'd1, 32'd1, 1'b0, -1, -1);
    run_op(32'd3, 32'd10, 1'b0, -1, -1);
    run_op(32'hFFFF_FFFD, 32'd10, 1'b1, -1, -1);
    run_op(32'h8000_0000, 32'd1, 1'b1, -1, -1);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, -1, -1);
    run_op(32'd50, 32'd5, 1'b0, 33, -1);
    run_op(32'd77, 32'd0, 1'b0, 1, -1);

    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) a = 32'($urandom_range(0, 30));
      annul_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 34)) : -1;
      run_op(a, b, 1'($urandom_range(0, 1)), annul_at, -1);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
